// File: rtl/xex_pkg.sv
// Shared types and constants for the xexaes256 stream front-end.
// Holds the job mode encodings, the FSM state type and the block geometry.
package xex_pkg;

    localparam logic [1:0] MODE_ENC = 2'b01;
    localparam logic [1:0] MODE_DEC = 2'b10;

    localparam int WORDS_PER_BLK = 4;
    localparam int WORD_IDX_W    = $clog2(WORDS_PER_BLK);
    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS_PER_BLK - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    function automatic logic mode_ok(input logic [1:0] mode);
        return (mode == MODE_ENC) || (mode == MODE_DEC);
    endfunction

endpackage

// File: rtl/xex_word_packer.sv
// 4x32 <-> 128-bit block register with a wrapping word index.
// Packs by inserting at the index, unpacks by parallel load plus index advance.
module xex_word_packer
    import xex_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clr,
    input  logic                  ld_en,
    input  logic [127:0]          ld_data,
    input  logic                  wr_en,
    input  logic [31:0]           wr_data,
    input  logic                  adv,
    output logic [127:0]          blk,
    output logic [WORD_IDX_W-1:0] idx
);

    logic [127:0]          blk_q, blk_d;
    logic [WORD_IDX_W-1:0] idx_q, idx_d;

    // Block and index registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            blk_q <= 128'd0;
            idx_q <= '0;
        end else begin
            blk_q <= blk_d;
            idx_q <= idx_d;
        end
    end

    // Parallel load restarts the index; otherwise insert and/or advance
    always_comb begin
        blk_d = blk_q;
        idx_d = idx_q;
        if (ld_en) begin
            blk_d = ld_data;
            idx_d = '0;
        end else begin
            if (wr_en) begin
                blk_d[{idx_q, 5'b00000} +: 32] = wr_data;
            end else begin
                blk_d = blk_q;
            end
            if (clr) begin
                idx_d = '0;
            end else if (adv) begin
                idx_d = idx_q + WORD_IDX_W'(1);
            end else begin
                idx_d = idx_q;
            end
        end
    end

    assign blk = blk_q;
    assign idx = idx_q;

endmodule

// File: rtl/xex_stream_ctrl.sv
// Job sequencer in front of xexaes256: packs 32-bit words into blocks, runs one
// block at a time through the engine under a watchdog, and streams results out.
module xex_stream_ctrl
    import xex_pkg::*;
#(
    parameter int BLK_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [127:0]     cmd_sector,
    input  logic [BLK_W-1:0] cmd_nblocks,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             done,
    output logic             err,
    output logic             xex_in_rdy,
    output logic [1:0]       xex_mode,
    output logic [127:0]     xex_sector,
    output logic [127:0]     xex_data_in,
    input  logic             xex_out_rdy,
    input  logic             xex_busy,
    input  logic [127:0]     xex_data_out
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [127:0]      sector_q, sector_d;
    logic [BLK_W-1:0]  nblk_q, nblk_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic                  ibuf_clr_s;
    logic                  s_hs_s, m_hs_s, cap_s;
    logic [127:0]          ibuf_s, obuf_s;
    logic [WORD_IDX_W-1:0] in_idx_s, out_idx_s;
    logic [BLK_W-1:0]      blk_inc_s;

    assign s_hs_s    = s_valid && (state_q == ST_LOAD);
    assign m_hs_s    = m_ready && (state_q == ST_DRAIN);
    assign cap_s     = xex_out_rdy && (state_q == ST_WAIT);
    assign blk_inc_s = blk_q + BLK_W'(1);

    xex_word_packer u_ibuf (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (ibuf_clr_s),
        .ld_en   (1'b0),
        .ld_data (128'd0),
        .wr_en   (s_hs_s),
        .wr_data (s_data),
        .adv     (s_hs_s),
        .blk     (ibuf_s),
        .idx     (in_idx_s)
    );

    xex_word_packer u_obuf (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (1'b0),
        .ld_en   (cap_s),
        .ld_data (xex_data_out),
        .wr_en   (1'b0),
        .wr_data (32'd0),
        .adv     (m_hs_s),
        .blk     (obuf_s),
        .idx     (out_idx_s)
    );

    // FSM, job and watchdog registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= 2'b00;
            sector_q <= 128'd0;
            nblk_q   <= '0;
            blk_q    <= '0;
            wd_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            sector_q <= sector_d;
            nblk_q   <= nblk_d;
            blk_q    <= blk_d;
            wd_q     <= wd_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; mode/sector are cleared on every return to IDLE
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sector_d   = sector_q;
        nblk_d     = nblk_q;
        blk_d      = blk_q;
        wd_d       = wd_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ibuf_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (!mode_ok(cmd_mode)) begin
                        err_d = 1'b1;
                    end else if (cmd_nblocks == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_LOAD;
                        mode_d     = cmd_mode;
                        sector_d   = cmd_sector;
                        nblk_d     = cmd_nblocks;
                        blk_d      = '0;
                        ibuf_clr_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (s_hs_s && (in_idx_s == LAST_WORD)) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_ISSUE: begin
                if (!xex_busy) begin
                    state_d = ST_WAIT;
                    wd_d    = '0;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (xex_out_rdy) begin
                    state_d = ST_DRAIN;
                end else if (wd_q == WD_LAST) begin
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                    mode_d   = 2'b00;
                    sector_d = 128'd0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_DRAIN: begin
                if (m_hs_s && (out_idx_s == LAST_WORD)) begin
                    blk_d = blk_inc_s;
                    if (blk_inc_s == nblk_q) begin
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                        mode_d   = 2'b00;
                        sector_d = 128'd0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign s_ready     = (state_q == ST_LOAD);
    assign m_valid     = (state_q == ST_DRAIN);
    assign m_data      = obuf_s[{out_idx_s, 5'b00000} +: 32];
    assign xex_in_rdy  = (state_q == ST_ISSUE) && !xex_busy;
    assign xex_mode    = mode_q;
    assign xex_sector  = sector_q;
    assign xex_data_in = ibuf_s;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_xex_stream_ctrl.sv
// Scoreboard bench for xex_stream_ctrl with a behavioural engine model.
module tb_xex_stream_ctrl;
    import xex_pkg::*;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_mode = 2'b00;
    logic [127:0] cmd_sector = 128'd0;
    logic [7:0]   cmd_nblocks = 8'd0;
    logic [31:0]  s_data = 32'd0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic         done, err;
    logic         xex_in_rdy;
    logic [1:0]   xex_mode;
    logic [127:0] xex_sector, xex_data_in;
    logic         xex_out_rdy = 1'b0;
    logic         xex_busy = 1'b0;
    logic [127:0] xex_data_out = 128'd0;

    xex_stream_ctrl #(.BLK_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .n_rst(n_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_sector(cmd_sector), .cmd_nblocks(cmd_nblocks),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .done(done), .err(err),
        .xex_in_rdy(xex_in_rdy), .xex_mode(xex_mode), .xex_sector(xex_sector),
        .xex_data_in(xex_data_in), .xex_out_rdy(xex_out_rdy),
        .xex_busy(xex_busy), .xex_data_out(xex_data_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0]  exp_m[$];
    logic [127:0] exp_in[$];
    int           inrdy_log[$];
    logic [1:0]   exp_mode = 2'b00;
    logic [127:0] exp_sector = 128'd0;
    int done_cnt = 0, err_cnt = 0, inrdy_cnt = 0, sready_cnt = 0;
    int done_cyc = 0, err_cyc = 0, acc_cyc = 0, issue_cyc = 0;
    logic err_cmdrdy = 1'b0;
    bit eng_on = 1'b1;
    bit eng_xor = 1'b0;
    int mr_mode = 0;

    always @(posedge clk) cyc++;

    task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: stream scoreboard, engine-side checks, pulse bookkeeping
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                if (exp_m.size() == 0) chk_val("m_extra", 128'd1, 128'd0);
                else begin
                    chk_val("m_data", m_data, exp_m[0]);
                    if (m_ready) void'(exp_m.pop_front());
                end
            end
            if (xex_in_rdy) begin
                inrdy_cnt++;
                inrdy_log.push_back(cyc);
                chk_val("in_busy", xex_busy, 1'b0);
                chk_val("xmode", xex_mode, exp_mode);
                chk_val("xsector", xex_sector, exp_sector);
                if (exp_in.size() == 0) chk_val("in_extra", 128'd1, 128'd0);
                else chk_val("data_in", xex_data_in, exp_in.pop_front());
            end
            if (s_ready) sready_cnt++;
            if (done && err) chk_val("done_err_excl", 128'd1, 128'd0);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) begin err_cnt++; err_cyc = cyc; err_cmdrdy = cmd_ready; end
        end
    end

    // Engine model: answers three cycles after in_rdy
    initial begin
        logic [127:0] din;
        forever begin
            @(negedge clk);
            if (xex_in_rdy && eng_on) begin
                din = xex_data_in;
                repeat (3) @(posedge clk);
                #1;
                xex_out_rdy  = 1'b1;
                xex_data_out = eng_xor ? ~din : {4{32'hA5A5A5A5}};
                @(posedge clk);
                #1 xex_out_rdy = 1'b0;
            end
        end
    end

    // Downstream ready pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic chk_reset_outs();
        chk_val("rst_cmd_ready", cmd_ready, 1'b1);
        chk_val("rst_s_ready", s_ready, 1'b0);
        chk_val("rst_m_valid", m_valid, 1'b0);
        chk_val("rst_m_data", m_data, 32'd0);
        chk_val("rst_done", done, 1'b0);
        chk_val("rst_err", err, 1'b0);
        chk_val("rst_in_rdy", xex_in_rdy, 1'b0);
        chk_val("rst_xmode", xex_mode, 2'b00);
        chk_val("rst_xsector", xex_sector, 128'd0);
        chk_val("rst_xdata_in", xex_data_in, 128'd0);
    endtask

    task automatic send_cmd(input logic [1:0] md, input logic [127:0] sec, input int nb);
        cmd_mode = md; cmd_sector = sec; cmd_nblocks = 8'(nb); cmd_valid = 1'b1;
        acc_cyc = cyc;
        @(negedge clk);
        chk_val("cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok = 1'b0;
        s_data = w; s_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!ok) chk_val("s_timeout", 128'd0, 128'd1);
    endtask

    task automatic send_block(input int b, input int busy_blk);
        logic [127:0] blkv;
        logic [31:0]  w;
        int base;
        for (int wi = 0; wi < 4; wi++) begin
            base = 16 * b + 4 * wi;
            w = {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
            blkv[32*wi +: 32] = w;
            exp_m.push_back(eng_xor ? ~w : 32'hA5A5A5A5);
            if (wi == 3 && b == busy_blk) xex_busy = 1'b1;
            send_word(w);
        end
        exp_in.push_back(blkv);
        if (b == busy_blk) begin
            issue_cyc = cyc;
            fork
                begin
                    repeat (5) @(posedge clk);
                    #1 xex_busy = 1'b0;
                end
            join_none
        end
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 500 && done_cnt == d0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [1:0] md, input logic [127:0] sec, input int nb, input int busy_blk);
        int d0 = done_cnt;
        int i0 = inrdy_cnt;
        exp_mode = md; exp_sector = sec;
        inrdy_log.delete();
        send_cmd(md, sec, nb);
        for (int b = 0; b < nb; b++) send_block(b, busy_blk);
        wait_done(d0);
        chk_val("done_pulses", done_cnt - d0, 1);
        chk_val("inrdy_pulses", inrdy_cnt - i0, nb);
        chk_val("m_left", exp_m.size(), 0);
        chk_val("in_left", exp_in.size(), 0);
    endtask

    initial begin
        int d0, e0, s0, i0;
        #12;
        chk_reset_outs();
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Encrypt, one block, constant engine response
        eng_xor = 1'b0;
        run_job(MODE_ENC, 128'h5, 1, -1);

        // Decrypt, three blocks, toggling m_ready, busy at second issue
        eng_xor = 1'b1;
        mr_mode = 1;
        run_job(MODE_DEC, 128'h1234_5678_9ABC_DEF0_0011_2233_4455_6677, 3, 1);
        if (inrdy_log.size() > 1) chk_val("busy_delay", inrdy_log[1] - issue_cyc, 5);
        else chk_val("busy_inrdy_seen", inrdy_log.size(), 2);
        mr_mode = 0;

        // Zero-block job
        d0 = done_cnt; s0 = sready_cnt; i0 = inrdy_cnt;
        send_cmd(MODE_ENC, 128'h9, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_val("zero_done", done_cnt - d0, 1);
        chk_val("zero_lat", done_cyc - acc_cyc, 1);
        chk_val("zero_sready", sready_cnt - s0, 0);
        chk_val("zero_inrdy", inrdy_cnt - i0, 0);

        // Reserved mode
        e0 = err_cnt; d0 = done_cnt; s0 = sready_cnt; i0 = inrdy_cnt;
        send_cmd(2'b11, 128'h7, 2);
        @(negedge clk);
        chk_val("rsv_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        chk_val("rsv_err", err_cnt - e0, 1);
        chk_val("rsv_lat", err_cyc - acc_cyc, 1);
        chk_val("rsv_err_cmdrdy", err_cmdrdy, 1'b1);
        chk_val("rsv_done", done_cnt - d0, 0);
        chk_val("rsv_sready", sready_cnt - s0, 0);
        chk_val("rsv_inrdy", inrdy_cnt - i0, 0);

        // Watchdog abort with a silent engine
        eng_on = 1'b0;
        e0 = err_cnt; d0 = done_cnt;
        exp_mode = MODE_ENC; exp_sector = 128'hC;
        inrdy_log.delete();
        send_cmd(MODE_ENC, 128'hC, 1);
        send_block(0, -1);
        for (int i = 0; i < 100 && err_cnt == e0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk_val("tmo_err", err_cnt - e0, 1);
        chk_val("tmo_done", done_cnt - d0, 0);
        if (inrdy_log.size() > 0) chk_val("tmo_lat", err_cyc - inrdy_log[0], 17);
        else chk_val("tmo_inrdy_seen", 0, 1);
        chk_val("tmo_idle", err_cmdrdy, 1'b1);
        exp_m.delete();
        eng_on = 1'b1;

        // Reset during the drain of the second block
        eng_xor = 1'b0;
        exp_mode = MODE_ENC; exp_sector = 128'h33;
        send_cmd(MODE_ENC, 128'h33, 3);
        send_block(0, -1);
        send_block(1, -1);
        mr_mode = 2;
        for (int i = 0; i < 100 && !m_valid; i++) @(negedge clk);
        chk_val("rst_in_drain", m_valid, 1'b1);
        d0 = done_cnt; e0 = err_cnt;
        #2 n_rst = 1'b0;
        #1;
        chk_reset_outs();
        exp_m.delete();
        exp_in.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        mr_mode = 0;
        @(posedge clk);
        #1;
        chk_val("rst_no_done", done_cnt - d0, 0);
        chk_val("rst_no_err", err_cnt - e0, 0);
        run_job(MODE_ENC, 128'h44, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
